// File: rtl/pi_pwm_actuator.sv
// PWM actuator endpoint: latches signed PI commands, scales/clamps them into a
// duty count, and drives a fixed-period PWM whose duty changes only at period boundaries.
module pi_pwm_actuator #(
  parameter int unsigned PERIOD = 1000,
  parameter int unsigned CW     = 16,
  parameter int unsigned SHIFT  = 0
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          enable,
  input  logic [31:0]   cmd,
  input  logic          cmd_valid,
  output logic          pwm,
  output logic [CW-1:0] duty,
  output logic          period_start,
  output logic          sat_hi,
  output logic          sat_lo
);

  localparam int unsigned LAST = PERIOD - 1;

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_e;

  state_e       state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [31:0]   shadow_q, shadow_d;
  logic [CW-1:0] duty_q, duty_d;
  logic          pwm_q, pwm_d;
  logic          period_start_q, period_start_d;
  logic          sat_hi_q, sat_hi_d;
  logic          sat_lo_q, sat_lo_d;

  logic signed [31:0] scaled_c;
  logic [CW-1:0]      load_duty_c;
  logic               load_hi_c;
  logic               load_lo_c;
  logic               wrap_c;

  // State and datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= IDLE;
      cnt_q          <= '0;
      shadow_q       <= '0;
      duty_q         <= '0;
      pwm_q          <= 1'b0;
      period_start_q <= 1'b0;
      sat_hi_q       <= 1'b0;
      sat_lo_q       <= 1'b0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      shadow_q       <= shadow_d;
      duty_q         <= duty_d;
      pwm_q          <= pwm_d;
      period_start_q <= period_start_d;
      sat_hi_q       <= sat_hi_d;
      sat_lo_q       <= sat_lo_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (enable)  state_d = RUN;
      RUN:     if (!enable) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Load value: a command on this cycle bypasses the shadow register
  always_comb begin
    scaled_c    = $signed(cmd_valid ? cmd : shadow_q) >>> SHIFT;
    load_duty_c = scaled_c[CW-1:0];
    load_hi_c   = 1'b0;
    load_lo_c   = 1'b0;
    if (scaled_c < 0) begin
      load_duty_c = '0;
      load_lo_c   = 1'b1;
    end else if (scaled_c > $signed(32'(PERIOD))) begin
      load_duty_c = CW'(PERIOD);
      load_hi_c   = 1'b1;
    end
  end

  assign wrap_c = (cnt_q == CW'(LAST));

  // Datapath / output logic
  always_comb begin
    cnt_d          = cnt_q;
    shadow_d       = cmd_valid ? cmd : shadow_q;
    duty_d         = duty_q;
    sat_hi_d       = sat_hi_q;
    sat_lo_d       = sat_lo_q;
    period_start_d = 1'b0;
    if (state_q == IDLE) begin
      cnt_d = '0;
      if (enable) begin
        duty_d         = load_duty_c;
        sat_hi_d       = load_hi_c;
        sat_lo_d       = load_lo_c;
        period_start_d = 1'b1;
      end
    end else if (!enable) begin
      cnt_d = '0;
    end else if (wrap_c) begin
      cnt_d          = '0;
      duty_d         = load_duty_c;
      sat_hi_d       = load_hi_c;
      sat_lo_d       = load_lo_c;
      period_start_d = 1'b1;
    end else begin
      cnt_d = cnt_q + CW'(1);
    end
    // Registered from next-state values so the pulse starts on the period_start cycle
    pwm_d = (state_d == RUN) && (cnt_d < duty_d);
  end

  assign pwm          = pwm_q;
  assign duty         = duty_q;
  assign period_start = period_start_q;
  assign sat_hi       = sat_hi_q;
  assign sat_lo       = sat_lo_q;

endmodule
